// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - fetch-to-decode instruction FIFO with major ID stamping
//
// Purpose:
//   Buffers instruction words from the fetch unit and stamps each accepted
//   word with a monotonically increasing major ID. It then issues the words
//   one per cycle to decode stage 1 over an enable/stall interface. Pushed
//   words are not bypassed: a word written at one edge is loaded into the
//   output registers at the next edge at the earliest.
//
// Optional feature:
//   FETCH_QUEUE_FLUSH_EN - adds flush_i (synchronous, active-high). A flush
//   empties the queue and clears outputEnable_o. The major ID counter keeps
//   running, so IDs stay unique across flushes.
//
// Ports:
//   clock_i              rising-edge clock
//   reset_i              asynchronous active-low reset
//   flush_i              queue flush (only with FETCH_QUEUE_FLUSH_EN)
//   fetchValid_i         fetch presents a word this cycle
//   fetchReady_o         queue can accept a word this cycle
//   fetchInstruction_i   fetched word
//   fetchAddress_i       word address
//   fetchPid_i           process ID
//   fetchTid_i           thread ID
//   stall_i              decode stall: outputs hold, no pop
//   outputEnable_o       outputs carry a newly issued instruction
//   instruction_o        issued instruction word
//   instructionAddress_o issued address
//   instructionPid_o     issued process ID
//   instructionTid_o     issued thread ID
//   instructionMajId_o   issued major ID
//   occupancy_o          number of entries currently queued

module fetch_issue_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 8,
  parameter int queueAddrWidth          = 3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
`ifdef FETCH_QUEUE_FLUSH_EN
  input  logic                               flush_i,
`endif
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [instructionWidth-1:0]        fetchInstruction_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  input  logic                               stall_i,
  output logic                               outputEnable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o,
  output logic [queueAddrWidth:0]            occupancy_o
);

  localparam logic [queueAddrWidth-1:0]          PtrOne     = (queueAddrWidth)'(1);
  localparam logic [queueAddrWidth:0]            OccOne     = (queueAddrWidth+1)'(1);
  localparam logic [queueAddrWidth:0]            DepthCount = (queueAddrWidth+1)'(queueDepth);
  localparam logic [instructionCounterWidth-1:0] IdOne      = (instructionCounterWidth)'(1);

  // Entry storage, one array per field.
  logic [instructionWidth-1:0]        instr_mem_q [queueDepth];
  logic [addressWidth-1:0]            addr_mem_q  [queueDepth];
  logic [PidSize-1:0]                 pid_mem_q   [queueDepth];
  logic [TidSize-1:0]                 tid_mem_q   [queueDepth];
  logic [instructionCounterWidth-1:0] id_mem_q    [queueDepth];

  logic [queueAddrWidth-1:0]          wr_ptr_q, wr_ptr_d;
  logic [queueAddrWidth-1:0]          rd_ptr_q, rd_ptr_d;
  logic [queueAddrWidth:0]            occ_q, occ_d;
  logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;

  logic                               out_en_q, out_en_d;
  logic [instructionWidth-1:0]        out_instr_q, out_instr_d;
  logic [addressWidth-1:0]            out_addr_q, out_addr_d;
  logic [PidSize-1:0]                 out_pid_q, out_pid_d;
  logic [TidSize-1:0]                 out_tid_q, out_tid_d;
  logic [instructionCounterWidth-1:0] out_id_q, out_id_d;

  logic fetch_ready;
  logic push;
  logic pop;
  logic mem_we;

  // Ready depends only on registered occupancy. It is also forced low
  // while reset is held, when occupancy alone would report space.
  assign fetch_ready = reset_i && (occ_q < DepthCount);

  always_comb begin
    push        = fetchValid_i && fetch_ready;
    pop         = !stall_i && (occ_q != '0);
    mem_we      = push;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    maj_id_d    = maj_id_q;
    out_en_d    = out_en_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_pid_d   = out_pid_q;
    out_tid_d   = out_tid_q;
    out_id_d    = out_id_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      maj_id_d = maj_id_q + IdOne;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PtrOne;
      out_en_d    = 1'b1;
      out_instr_d = instr_mem_q[rd_ptr_q];
      out_addr_d  = addr_mem_q[rd_ptr_q];
      out_pid_d   = pid_mem_q[rd_ptr_q];
      out_tid_d   = tid_mem_q[rd_ptr_q];
      out_id_d    = id_mem_q[rd_ptr_q];
    end else if (!stall_i) begin
      // Empty and not stalled: drop enable, keep the last data visible.
      out_en_d = 1'b0;
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase

`ifdef FETCH_QUEUE_FLUSH_EN
    // Flush overrides push, pop and stall. The ID counter is left alone
    // so that IDs issued after the flush never repeat earlier ones.
    if (flush_i) begin
      mem_we      = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      maj_id_d    = maj_id_q;
      out_en_d    = 1'b0;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      out_pid_d   = out_pid_q;
      out_tid_d   = out_tid_q;
      out_id_d    = out_id_q;
    end
`endif
  end

  // Storage is not reset; occupancy decides which entries are valid.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      instr_mem_q[wr_ptr_q] <= fetchInstruction_i;
      addr_mem_q[wr_ptr_q]  <= fetchAddress_i;
      pid_mem_q[wr_ptr_q]   <= fetchPid_i;
      tid_mem_q[wr_ptr_q]   <= fetchTid_i;
      id_mem_q[wr_ptr_q]    <= maj_id_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      maj_id_q    <= '0;
      out_en_q    <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      out_pid_q   <= '0;
      out_tid_q   <= '0;
      out_id_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      maj_id_q    <= maj_id_d;
      out_en_q    <= out_en_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_pid_q   <= out_pid_d;
      out_tid_q   <= out_tid_d;
      out_id_q    <= out_id_d;
    end
  end

  assign fetchReady_o         = fetch_ready;
  assign outputEnable_o       = out_en_q;
  assign instruction_o        = out_instr_q;
  assign instructionAddress_o = out_addr_q;
  assign instructionPid_o     = out_pid_q;
  assign instructionTid_o     = out_tid_q;
  assign instructionMajId_o   = out_id_q;
  assign occupancy_o          = occ_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - directed self-checking bench for fetch_issue_queue

module tb_fetch_issue_queue;

  localparam int IdW = 4;

  logic           clock_i = 1'b0;
  logic           reset_i;
`ifdef FETCH_QUEUE_FLUSH_EN
  logic           flush_i;
`endif
  logic           fetchValid_i;
  logic           fetchReady_o;
  logic [31:0]    fetchInstruction_i;
  logic [63:0]    fetchAddress_i;
  logic [19:0]    fetchPid_i;
  logic [15:0]    fetchTid_i;
  logic           stall_i;
  logic           outputEnable_o;
  logic [31:0]    instruction_o;
  logic [63:0]    instructionAddress_o;
  logic [19:0]    instructionPid_o;
  logic [15:0]    instructionTid_o;
  logic [IdW-1:0] instructionMajId_o;
  logic [3:0]     occupancy_o;

  int checks = 0;
  int errors = 0;

  always #5 clock_i = ~clock_i;

  fetch_issue_queue #(
    .instructionCounterWidth(IdW)
  ) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
`ifdef FETCH_QUEUE_FLUSH_EN
    .flush_i              (flush_i),
`endif
    .fetchValid_i         (fetchValid_i),
    .fetchReady_o         (fetchReady_o),
    .fetchInstruction_i   (fetchInstruction_i),
    .fetchAddress_i       (fetchAddress_i),
    .fetchPid_i           (fetchPid_i),
    .fetchTid_i           (fetchTid_i),
    .stall_i              (stall_i),
    .outputEnable_o       (outputEnable_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .instructionPid_o     (instructionPid_o),
    .instructionTid_o     (instructionTid_o),
    .instructionMajId_o   (instructionMajId_o),
    .occupancy_o          (occupancy_o)
  );

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] a);
    fetchValid_i       = v;
    fetchInstruction_i = ins;
    fetchAddress_i     = a;
    fetchPid_i         = ins[19:0] ^ 20'h5A5A5;
    fetchTid_i         = ins[15:0] ^ 16'h0F0F;
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    stall_i = 1'b0;
`ifdef FETCH_QUEUE_FLUSH_EN
    flush_i = 1'b0;
`endif
    drive(1'b0, 32'h0, 64'h0);
    tick;
    tick;
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", outputEnable_o); end
    checks++; if (instruction_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction_o); end
    checks++; if (instructionAddress_o !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", instructionAddress_o); end
    checks++; if (instructionMajId_o !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", instructionMajId_o); end
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy_o); end
    checks++; if (fetchReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b expected 0", fetchReady_o); end
    reset_i = 1'b1;
    #1;
    checks++; if (fetchReady_o !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0b expected 1", fetchReady_o); end
  endtask

  // Five words streamed with no stall; IDs 0..4 leave one edge after entry.
  task automatic test_basic;
    logic           exp_en;
    logic [31:0]    exp_ins;
    logic [63:0]    exp_addr;
    logic [IdW-1:0] exp_id;
    for (int i = 0; i < 7; i++) begin
      drive(i < 5, 32'h7C000000 + 32'(i), 64'h1000 + 64'(4 * i));
      tick;
      exp_en   = (i >= 1) && (i <= 5);
      exp_ins  = 32'h7C000000 + 32'(i - 1);
      exp_addr = 64'h1000 + 64'(4 * (i - 1));
      exp_id   = IdW'(i - 1);
      checks++; if (outputEnable_o !== exp_en) begin errors++; $display("FAIL basic_en[%0d]: got %0b expected %0b", i, outputEnable_o, exp_en); end
      if (exp_en) begin
        checks++; if (instructionMajId_o !== exp_id) begin errors++; $display("FAIL basic_id[%0d]: got %0d expected %0d", i, instructionMajId_o, exp_id); end
        checks++; if (instruction_o !== exp_ins) begin errors++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, instruction_o, exp_ins); end
        checks++; if (instructionAddress_o !== exp_addr) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, instructionAddress_o, exp_addr); end
        checks++; if (instructionPid_o !== (exp_ins[19:0] ^ 20'h5A5A5)) begin errors++; $display("FAIL basic_pid[%0d]: got %h expected %h", i, instructionPid_o, exp_ins[19:0] ^ 20'h5A5A5); end
        checks++; if (instructionTid_o !== (exp_ins[15:0] ^ 16'h0F0F)) begin errors++; $display("FAIL basic_tid[%0d]: got %h expected %h", i, instructionTid_o, exp_ins[15:0] ^ 16'h0F0F); end
      end
    end
  endtask

  // Fill under stall (IDs 5..12), 9th push ignored, then drain in order.
  task automatic test_full;
    logic [IdW-1:0] exp_id;
    stall_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (fetchReady_o !== (i < 8)) begin errors++; $display("FAIL full_ready[%0d]: got %0b expected %0b", i, fetchReady_o, i < 8); end
      drive(1'b1, 32'hA0000000 + 32'(i), 64'h2000 + 64'(8 * i));
      tick;
    end
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (occupancy_o !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d expected 8", occupancy_o); end
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL full_en_held: got %0b expected 0", outputEnable_o); end
    stall_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      exp_id = IdW'(5 + k);
      checks++; if (outputEnable_o !== 1'b1) begin errors++; $display("FAIL full_drain_en[%0d]: got %0b expected 1", k, outputEnable_o); end
      checks++; if (instructionMajId_o !== exp_id) begin errors++; $display("FAIL full_drain_id[%0d]: got %0d expected %0d", k, instructionMajId_o, exp_id); end
      checks++; if (instruction_o !== 32'hA0000000 + 32'(k)) begin errors++; $display("FAIL full_drain_instr[%0d]: got %h expected %h", k, instruction_o, 32'hA0000000 + 32'(k)); end
    end
    tick;
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL full_no_ninth: got %0b expected 0", outputEnable_o); end
  endtask

  // Freeze outputs at ID 3 for four stalled cycles, then resume with ID 4.
  task automatic test_stall_hold;
    reset_i = 1'b0;
    tick;
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hC0000000 + 32'(i), 64'h4000 + 64'(4 * i));
      tick;
    end
    checks++; if (instructionMajId_o !== 4'd3) begin errors++; $display("FAIL stall_pre_id: got %0d expected 3", instructionMajId_o); end
    stall_i = 1'b1;
    drive(1'b1, 32'hC0000005, 64'h4014);
    for (int c = 0; c < 4; c++) begin
      tick;
      drive(1'b0, 32'h0, 64'h0);
      checks++; if (outputEnable_o !== 1'b1) begin errors++; $display("FAIL stall_en[%0d]: got %0b expected 1", c, outputEnable_o); end
      checks++; if (instructionMajId_o !== 4'd3) begin errors++; $display("FAIL stall_id[%0d]: got %0d expected 3", c, instructionMajId_o); end
      checks++; if (instruction_o !== 32'hC0000003) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected C0000003", c, instruction_o); end
    end
    checks++; if (occupancy_o !== 4'd2) begin errors++; $display("FAIL stall_occ: got %0d expected 2", occupancy_o); end
    stall_i = 1'b0;
    tick;
    checks++; if (instructionMajId_o !== 4'd4) begin errors++; $display("FAIL stall_release_id4: got %0d expected 4", instructionMajId_o); end
    tick;
    checks++; if (instructionMajId_o !== 4'd5) begin errors++; $display("FAIL stall_release_id5: got %0d expected 5", instructionMajId_o); end
    tick;
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL stall_empty_en: got %0b expected 0", outputEnable_o); end
  endtask

  // Full queue: push refused on the popping cycle, accepted on the next.
  task automatic test_full_pushpop;
    logic [31:0]    exp_ins;
    logic [IdW-1:0] exp_id;
    stall_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hD0000000 + 32'(i), 64'h5000 + 64'(4 * i));
      tick;
    end
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (fetchReady_o !== 1'b0) begin errors++; $display("FAIL fpp_ready_full: got %0b expected 0", fetchReady_o); end
    stall_i = 1'b0;
    drive(1'b1, 32'hE0000000, 64'h6000);
    tick;
    checks++; if (occupancy_o !== 4'd7) begin errors++; $display("FAIL fpp_occ_refused: got %0d expected 7", occupancy_o); end
    checks++; if (instructionMajId_o !== 4'd6) begin errors++; $display("FAIL fpp_id6: got %0d expected 6", instructionMajId_o); end
    checks++; if (fetchReady_o !== 1'b1) begin errors++; $display("FAIL fpp_ready_rise: got %0b expected 1", fetchReady_o); end
    tick;
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (occupancy_o !== 4'd7) begin errors++; $display("FAIL fpp_occ_pushpop: got %0d expected 7", occupancy_o); end
    checks++; if (instructionMajId_o !== 4'd7) begin errors++; $display("FAIL fpp_id7: got %0d expected 7", instructionMajId_o); end
    for (int k = 0; k < 7; k++) begin
      tick;
      exp_id  = IdW'(8 + k);
      exp_ins = (k < 6) ? 32'hD0000002 + 32'(k) : 32'hE0000000;
      checks++; if (instructionMajId_o !== exp_id) begin errors++; $display("FAIL fpp_drain_id[%0d]: got %0d expected %0d", k, instructionMajId_o, exp_id); end
      checks++; if (instruction_o !== exp_ins) begin errors++; $display("FAIL fpp_drain_instr[%0d]: got %h expected %h", k, instruction_o, exp_ins); end
    end
    tick;
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL fpp_empty_en: got %0b expected 0", outputEnable_o); end
  endtask

  // Counter at 15: the 4-bit major ID wraps 15,0,1,2.
  task automatic test_wrap;
    logic [IdW-1:0] exp_id;
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, 32'hF0000000 + 32'(i), 64'h7000 + 64'(4 * i));
      tick;
      if (i >= 1 && i <= 4) begin
        exp_id = IdW'(15 + i - 1);
        checks++; if (outputEnable_o !== 1'b1) begin errors++; $display("FAIL wrap_en[%0d]: got %0b expected 1", i, outputEnable_o); end
        checks++; if (instructionMajId_o !== exp_id) begin errors++; $display("FAIL wrap_id[%0d]: got %0d expected %0d", i, instructionMajId_o, exp_id); end
      end
    end
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL wrap_empty_en: got %0b expected 0", outputEnable_o); end
  endtask

  // Asynchronous reset with 5 entries queued; first new word gets ID 0.
  task automatic test_async_reset;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h90000000 + 32'(i), 64'h8000 + 64'(4 * i));
      tick;
    end
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (occupancy_o !== 4'd5) begin errors++; $display("FAIL arst_pre_occ: got %0d expected 5", occupancy_o); end
    #2;
    reset_i = 1'b0;
    #1;
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL arst_occ: got %0d expected 0", occupancy_o); end
    checks++; if (instruction_o !== 32'h0) begin errors++; $display("FAIL arst_instr: got %h expected 0", instruction_o); end
    checks++; if (instructionMajId_o !== 4'd0) begin errors++; $display("FAIL arst_id: got %0d expected 0", instructionMajId_o); end
    checks++; if (fetchReady_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %0b expected 0", fetchReady_o); end
    reset_i = 1'b1;
    stall_i = 1'b0;
    drive(1'b1, 32'h11111111, 64'h3000);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL arst_latency_en: got %0b expected 0", outputEnable_o); end
    tick;
    checks++; if (outputEnable_o !== 1'b1) begin errors++; $display("FAIL arst_first_en: got %0b expected 1", outputEnable_o); end
    checks++; if (instructionMajId_o !== 4'd0) begin errors++; $display("FAIL arst_first_id: got %0d expected 0", instructionMajId_o); end
    checks++; if (instruction_o !== 32'h11111111) begin errors++; $display("FAIL arst_first_instr: got %h expected 11111111", instruction_o); end
    tick;
  endtask

`ifdef FETCH_QUEUE_FLUSH_EN
  // Flush under stall with IDs 2..6 queued; coincident push dropped; next ID 7.
  task automatic test_flush;
    drive(1'b1, 32'h22222222, 64'h9000);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    tick;
    checks++; if (instructionMajId_o !== 4'd1) begin errors++; $display("FAIL flush_pre_id: got %0d expected 1", instructionMajId_o); end
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h55550000 + 32'(i), 64'h9100 + 64'(4 * i));
      tick;
    end
    checks++; if (occupancy_o !== 4'd5) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 5", occupancy_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'h33333333, 64'h9200);
    tick;
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy_o); end
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL flush_en: got %0b expected 0", outputEnable_o); end
    stall_i = 1'b0;
    drive(1'b1, 32'h44444444, 64'h9300);
    tick;
    drive(1'b0, 32'h0, 64'h0);
    tick;
    checks++; if (instructionMajId_o !== 4'd7) begin errors++; $display("FAIL flush_next_id: got %0d expected 7", instructionMajId_o); end
    checks++; if (instruction_o !== 32'h44444444) begin errors++; $display("FAIL flush_next_instr: got %h expected 44444444", instruction_o); end
    tick;
    checks++; if (outputEnable_o !== 1'b0) begin errors++; $display("FAIL flush_empty_en: got %0b expected 0", outputEnable_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_stall_hold;
    test_full_pushpop;
    test_wrap;
    test_async_reset;
`ifdef FETCH_QUEUE_FLUSH_EN
    test_flush;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
